// File: rtl/apb_link.sv
// APB-style link: master SETUP/ACCESS FSM driving a small slave word memory.
// Optional macro APB_WAIT_STATE_EN makes the slave insert one wait state per access.
module apb_link #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              transfer,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PDATA,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PRWADDR,
  output logic [DATA_W-1:0] PRWDATA,
  output logic [DATA_W-1:0] PRDATA1,
  output logic              PREADY
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic              req;
  logic              done;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign req  = PSEL & transfer;
  assign done = PSEL & PENABLE & PREADY;
  assign idx  = PRWADDR[IDX_W-1:0];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = SETUP;
      SETUP:   state_n = req ? ACCESS : IDLE;
      ACCESS: begin
        if (!PSEL)       state_n = IDLE;
        else if (PREADY) state_n = req ? SETUP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // SETUP is never held, so state_n==SETUP marks exactly the entry edge
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      PENABLE <= 1'b0;
      PRWADDR <= '0;
      PRWDATA <= '0;
    end else begin
      state   <= state_n;
      PENABLE <= (state_n == ACCESS);
      if (state_n == SETUP) begin
        PRWADDR <= PADDR;
        PRWDATA <= PDATA;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PRDATA1 <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (done) begin
      if (PWRITE) begin
        mem[idx] <= PRWDATA;
        PRDATA1  <= PRWDATA;
      end else begin
        PRDATA1  <= mem[idx];
      end
    end
  end

`ifdef APB_WAIT_STATE_EN
  // First ACCESS cycle arms PREADY; the access completes on the following edge
  always_ff @(posedge PCLK) begin
    if (PRESET)             PREADY <= 1'b0;
    else if (!PSEL || done) PREADY <= 1'b0;
    else if (PENABLE)       PREADY <= 1'b1;
  end
`else
  assign PREADY = PSEL & PENABLE;
`endif

endmodule

// File: tb/tb_apb_link.sv
// Self-checking bench for apb_link: transaction-level memory model feeding a
// scoreboard queue, monitor pops on every completed access.
module tb_apb_link;

`ifdef APB_WAIT_STATE_EN
  localparam int W = 1;
`else
  localparam int W = 0;
`endif
  localparam int P = 2 + W;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        transfer = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PDATA = '0;
  logic        PENABLE;
  logic [31:0] PRWADDR;
  logic [31:0] PRWDATA;
  logic [31:0] PRDATA1;
  logic        PREADY;

  apb_link #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .transfer(transfer),
    .PWRITE(PWRITE), .PADDR(PADDR), .PDATA(PDATA), .PENABLE(PENABLE),
    .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRDATA1(PRDATA1), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [4];
  logic [31:0] last_out = '0;
  logic [31:0] exp_q [$];
  logic [31:0] stim_a [$];
  logic [31:0] stim_d [$];
  bit          pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Expected result of one access, from memory semantics alone
  task automatic expect_access(input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (wr) begin
      mdl[a % 4] = d;
      last_out   = d;
    end else begin
      last_out = mdl[a % 4];
    end
    exp_q.push_back(last_out);
  endtask

  // Monitor: a completion seen before an edge is checked after that edge
  always @(negedge PCLK) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got PRDATA1=0x%08h expected no access", PRDATA1);
      end else begin
        check("prdata1", PRDATA1, exp_q.pop_front());
      end
    end
    pend = !PRESET && PSEL && PENABLE && PREADY;
  end

  // Back-to-back burst of same-direction accesses taken from stim_a/stim_d
  task automatic burst(input bit wr);
    logic [31:0] a, d;
    PWRITE = wr; PSEL = 1'b1; transfer = 1'b1;
    while (stim_a.size() > 0) begin
      a = stim_a.pop_front();
      d = stim_d.pop_front();
      PADDR = a; PDATA = d;
      expect_access(wr, a, d);
      repeat (P) tick();
    end
    transfer = 1'b0;
    tick();
    PSEL = 1'b0; PADDR = $urandom; PDATA = $urandom;
  endtask

  task automatic one(input bit wr, input logic [31:0] a, input logic [31:0] d);
    stim_a.push_back(a);
    stim_d.push_back(d);
    burst(wr);
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) begin
      stim_a.push_back(i);
      stim_d.push_back($urandom);
    end
    burst(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    repeat (3) tick();
    PRESET = 1'b0;
    check("rst_penable", {31'b0, PENABLE}, 32'd0);
    check("rst_prwaddr", PRWADDR, 32'd0);
    check("rst_prwdata", PRWDATA, 32'd0);
    check("rst_prdata1", PRDATA1, 32'd0);
    check("rst_pready", {31'b0, PREADY}, 32'd0);

    // First write with phase-by-phase latency check
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'd0; PDATA = 32'h309;
    expect_access(1'b1, 32'd0, 32'h309);
    tick();
    check("setup_penable", {31'b0, PENABLE}, 32'd0);
    check("setup_prwaddr", PRWADDR, 32'd0);
    check("setup_prwdata", PRWDATA, 32'h309);
    tick();
    check("access_penable", {31'b0, PENABLE}, 32'd1);
    if (W == 1) begin
      tick();
      check("wait_penable", {31'b0, PENABLE}, 32'd1);
    end
    transfer = 1'b0;
    tick();
    check("done_penable", {31'b0, PENABLE}, 32'd0);
    check("done_prdata1", PRDATA1, 32'h309);
    PSEL = 1'b0;
    repeat (2) tick();

    one(1'b1, 32'd1, 32'h07122023); repeat (2) tick();
    one(1'b1, 32'd2, 32'h444f4c5a); repeat (2) tick();
    one(1'b1, 32'd3, 32'h44454e49); repeat (2) tick();
    read_all();
    tick();

    // Address wrap
    one(1'b1, 32'd5, 32'hA5);
    tick();
    one(1'b0, 32'd1, 32'h0);
    tick();

    // Abort in SETUP
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'd2; PDATA = 32'hDEAD0001;
    tick();
    PSEL = 1'b0; transfer = 1'b0;
    tick();
    check("abort_setup_penable", {31'b0, PENABLE}, 32'd0);
    tick();
    check("abort_setup_penable2", {31'b0, PENABLE}, 32'd0);
    check("abort_setup_prdata1", PRDATA1, last_out);

    // Abort in ACCESS
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'd3; PDATA = 32'hDEAD0002;
    tick();
    tick();
    check("abort_access_entered", {31'b0, PENABLE}, 32'd1);
    PSEL = 1'b0; transfer = 1'b0;
    tick();
    check("abort_access_penable", {31'b0, PENABLE}, 32'd0);
    check("abort_access_prdata1", PRDATA1, last_out);
    tick();
    read_all();
    tick();

    // Randomized bursts
    for (int k = 0; k < 25; k++) begin
      int n;
      bit wr;
      n  = $urandom_range(1, 4);
      wr = $urandom_range(0, 1);
      for (int j = 0; j < n; j++) begin
        stim_a.push_back($urandom_range(0, 15));
        stim_d.push_back($urandom);
      end
      burst(wr);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (2) tick();

    // Reset in the middle of ACCESS
    PSEL = 1'b1; transfer = 1'b1; PWRITE = 1'b1; PADDR = 32'd1; PDATA = 32'hBEEF;
    tick();
    tick();
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    check("midrst_penable", {31'b0, PENABLE}, 32'd0);
    check("midrst_prwaddr", PRWADDR, 32'd0);
    check("midrst_prwdata", PRWDATA, 32'd0);
    check("midrst_prdata1", PRDATA1, 32'd0);
    check("midrst_pready", {31'b0, PREADY}, 32'd0);
    PSEL = 1'b0; transfer = 1'b0;
    tick();
    read_all();

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
